// File: rtl/vmem_writer_if.sv
// Drawing-command handshake between a command source and vmem_writer.
// The source drives the command fields; the engine answers with cmd_ready.
interface vmem_writer_if #(
    parameter int H_BITS = 10,
    parameter int V_BITS = 9,
    parameter int DATA_W = 24
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [H_BITS-1:0] cmd_x0;
    logic [V_BITS-1:0] cmd_y0;
    logic [H_BITS-1:0] cmd_x1;
    logic [V_BITS-1:0] cmd_y1;
    logic [DATA_W-1:0] cmd_color;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_x0,
        output cmd_y0,
        output cmd_x1,
        output cmd_y1,
        output cmd_color,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_x0,
        input  cmd_y0,
        input  cmd_x1,
        input  cmd_y1,
        input  cmd_color,
        output cmd_ready
    );
endinterface

// File: rtl/vmem_writer.sv
// Write-side engine for the 24-bit video memory: pixel, filled rectangle
// and full-screen clear, one write per cycle, optionally only in vblank.
module vmem_writer #(
    parameter int H_BITS = 10,
    parameter int V_BITS = 9,
    parameter int DATA_W = 24,
    parameter int H_MAX  = 640,
    parameter int V_MAX  = 480
) (
    input  logic                     clk,
    input  logic                     rst,
    vmem_writer_if.slave             cmd,
    input  logic                     sync_en,
    input  logic                     vblank,
    output logic                     mem_we,
    output logic [H_BITS+V_BITS-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam logic [1:0] OP_PIX  = 2'b00;
    localparam logic [1:0] OP_FILL = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    localparam logic [H_BITS-1:0] X_LAST = H_BITS'(H_MAX - 1);
    localparam logic [V_BITS-1:0] Y_LAST = V_BITS'(V_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN,
        ERR
    } state_t;

    state_t state;

    logic              ready_q;
    logic              last_q;
    logic [H_BITS-1:0] cur_x;
    logic [V_BITS-1:0] cur_y;
    logic [H_BITS-1:0] x0_q;
    logic [H_BITS-1:0] x1_q;
    logic [V_BITS-1:0] y1_q;
    logic [DATA_W-1:0] color_q;

    logic [H_BITS-1:0] dec_x0;
    logic [V_BITS-1:0] dec_y0;
    logic [H_BITS-1:0] dec_x1;
    logic [V_BITS-1:0] dec_y1;
    logic [DATA_W-1:0] dec_color;
    logic              dec_ok;

    logic              take;
    logic              step;
    logic              gate;
    logic [H_BITS-1:0] src_x;
    logic [V_BITS-1:0] src_y;
    logic [H_BITS-1:0] src_x0;
    logic [H_BITS-1:0] src_x1;
    logic [V_BITS-1:0] src_y1;
    logic [DATA_W-1:0] src_color;
    logic              at_x_end;
    logic              at_end;
    logic [H_BITS-1:0] nxt_x;
    logic [V_BITS-1:0] nxt_y;

    assign cmd.cmd_ready = ready_q;

    // Turn the raw command into a rectangle and range-check it.
    always_comb begin
        dec_x0    = cmd.cmd_x0;
        dec_y0    = cmd.cmd_y0;
        dec_x1    = cmd.cmd_x1;
        dec_y1    = cmd.cmd_y1;
        dec_color = cmd.cmd_color;
        unique case (cmd.cmd_op)
            OP_PIX: begin
                dec_x1 = cmd.cmd_x0;
                dec_y1 = cmd.cmd_y0;
            end
            OP_FILL: begin
            end
            OP_CLR: begin
                dec_x0    = '0;
                dec_y0    = '0;
                dec_x1    = X_LAST;
                dec_y1    = Y_LAST;
                dec_color = '0;
            end
            default: begin
            end
        endcase
        dec_ok = (cmd.cmd_op != OP_RSV)
              && (dec_x0 <= dec_x1)
              && (dec_y0 <= dec_y1)
              && (dec_x1 <= X_LAST)
              && (dec_y1 <= Y_LAST);
    end

    // Cursor source: the incoming command on the accepting edge, else the
    // latched rectangle, so the first write can issue on the accept edge.
    always_comb begin
        take      = cmd.cmd_valid && ready_q;
        gate      = !sync_en || vblank;
        step      = take ? dec_ok : (state == RUN && !last_q);
        src_x     = take ? dec_x0    : cur_x;
        src_y     = take ? dec_y0    : cur_y;
        src_x0    = take ? dec_x0    : x0_q;
        src_x1    = take ? dec_x1    : x1_q;
        src_y1    = take ? dec_y1    : y1_q;
        src_color = take ? dec_color : color_q;
        at_x_end  = (src_x == src_x1);
        at_end    = at_x_end && (src_y == src_y1);
        nxt_x     = at_x_end ? src_x0 : src_x + H_BITS'(1);
        nxt_y     = at_x_end ? src_y + V_BITS'(1) : src_y;
    end

    // Command FSM, cursor walk and registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ready_q   <= 1'b1;
            last_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            color_q   <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            if (take) begin
                if (dec_ok) begin
                    state   <= RUN;
                    ready_q <= 1'b0;
                    busy    <= 1'b1;
                    last_q  <= 1'b0;
                    x0_q    <= dec_x0;
                    x1_q    <= dec_x1;
                    y1_q    <= dec_y1;
                    color_q <= dec_color;
                end else begin
                    state <= ERR;
                    err   <= 1'b1;
                end
            end else begin
                unique case (state)
                    RUN: begin
                        if (last_q) begin
                            state   <= FIN;
                            done    <= 1'b1;
                            ready_q <= 1'b1;
                            busy    <= 1'b0;
                            last_q  <= 1'b0;
                        end
                    end
                    FIN, ERR: state <= IDLE;
                    default: begin
                    end
                endcase
            end
            if (step) begin
                if (gate) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= {src_x, src_y};
                    mem_wdata <= src_color;
                    if (at_end) begin
                        last_q <= 1'b1;
                    end else begin
                        cur_x <= nxt_x;
                        cur_y <= nxt_y;
                    end
                end else begin
                    cur_x <= src_x;
                    cur_y <= src_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_vmem_writer.sv
// Directed bench for vmem_writer on a reduced 32x24 screen so that a
// full clear stays short; addressing keeps the 10+9 bit layout.
module tb_vmem_writer;

    localparam int HB = 10;
    localparam int VB = 9;
    localparam int DW = 24;
    localparam int HM = 32;
    localparam int VM = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sync_en = 1'b0;
    logic          vblank = 1'b0;
    logic          mem_we;
    logic [HB+VB-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          done;
    logic          err;

    int n_chk = 0;
    int n_pass = 0;

    vmem_writer_if #(.H_BITS(HB), .V_BITS(VB), .DATA_W(DW)) bus ();

    vmem_writer #(
        .H_BITS(HB), .V_BITS(VB), .DATA_W(DW), .H_MAX(HM), .V_MAX(VM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (bus),
        .sync_en  (sync_en),
        .vblank   (vblank),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] xy(input logic [9:0] x, input logic [8:0] y);
        return {x, y};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called just after a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [1:0] op, input logic [9:0] x0,
                        input logic [8:0] y0, input logic [9:0] x1,
                        input logic [8:0] y1, input logic [23:0] c);
        int k = 0;
        while (!bus.cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("send_ready", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_op    = op;
        bus.cmd_x0    = x0;
        bus.cmd_y0    = y0;
        bus.cmd_x1    = x1;
        bus.cmd_y1    = y1;
        bus.cmd_color = c;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    logic [18:0] fill_a [4];
    logic        vb_seq [7];
    logic [18:0] g_a    [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nw;
        int bad;
        int stray;
        int gi;
        logic [18:0] last_a;
        logic prev_we;
        logic seen_done;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_x0    = '0;
        bus.cmd_y0    = '0;
        bus.cmd_x1    = '0;
        bus.cmd_y1    = '0;
        bus.cmd_color = '0;

        fill_a = '{19'h01414, 19'h01614, 19'h01415, 19'h01615};
        vb_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        g_a    = '{19'h00407, 19'h00607, 19'h00807, 19'h00A07};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_we", {31'd0, mem_we}, 0);
        chk("rst_addr", {13'd0, mem_addr}, 0);
        chk("rst_wdata", {8'd0, mem_wdata}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.cmd_ready}, 1);

        // single pixel
        send(2'b00, 10'd5, 9'd3, 10'd0, 9'd0, 24'hFF0000);
        chk("pix_we", {31'd0, mem_we}, 1);
        chk("pix_addr", {13'd0, mem_addr}, 32'h00A03);
        chk("pix_data", {8'd0, mem_wdata}, 32'hFF0000);
        chk("pix_busy", {31'd0, busy}, 1);
        chk("pix_ready", {31'd0, bus.cmd_ready}, 0);
        chk("pix_done0", {31'd0, done}, 0);
        @(negedge clk);
        chk("pix_done", {31'd0, done}, 1);
        chk("pix_we_off", {31'd0, mem_we}, 0);
        chk("pix_busy_off", {31'd0, busy}, 0);
        chk("pix_ready_fin", {31'd0, bus.cmd_ready}, 1);
        chk("pix_addr_hold", {13'd0, mem_addr}, 32'h00A03);

        // 2x2 fill accepted on the done cycle
        send(2'b01, 10'd10, 9'd20, 10'd11, 9'd21, 24'h00FF00);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill_we%0d", i), {31'd0, mem_we}, 1);
            chk($sformatf("fill_addr%0d", i), {13'd0, mem_addr}, {13'd0, fill_a[i]});
            chk($sformatf("fill_data%0d", i), {8'd0, mem_wdata}, 32'h00FF00);
            chk($sformatf("fill_busy%0d", i), {31'd0, busy}, 1);
            @(negedge clk);
        end
        chk("fill_done", {31'd0, done}, 1);
        chk("fill_we_off", {31'd0, mem_we}, 0);
        chk("fill_busy_off", {31'd0, busy}, 0);
        @(negedge clk);
        chk("fill_done_pulse", {31'd0, done}, 0);

        // rejected commands
        send(2'b01, 10'd12, 9'd0, 10'd11, 9'd0, 24'h111111);
        chk("badx_err", {31'd0, err}, 1);
        chk("badx_we", {31'd0, mem_we}, 0);
        chk("badx_ready", {31'd0, bus.cmd_ready}, 1);
        chk("badx_busy", {31'd0, busy}, 0);
        chk("badx_done", {31'd0, done}, 0);
        @(negedge clk);
        chk("badx_err_pulse", {31'd0, err}, 0);
        send(2'b00, 10'd640, 9'd0, 10'd0, 9'd0, 24'h222222);
        chk("pix640_err", {31'd0, err}, 1);
        chk("pix640_we", {31'd0, mem_we}, 0);
        @(negedge clk);
        send(2'b11, 10'd0, 9'd0, 10'd0, 9'd0, 24'h333333);
        chk("rsv_err", {31'd0, err}, 1);
        @(negedge clk);
        send(2'b01, 10'd0, 9'd0, 10'd0, 9'd24, 24'h444444);
        chk("bady1_err", {31'd0, err}, 1);
        @(negedge clk);
        send(2'b01, 10'd0, 9'd5, 10'd0, 9'd4, 24'h555555);
        chk("bady_err", {31'd0, err}, 1);
        @(negedge clk);

        // last legal pixel
        send(2'b00, 10'd31, 9'd23, 10'd0, 9'd0, 24'h0000AA);
        chk("edge_err", {31'd0, err}, 0);
        chk("edge_we", {31'd0, mem_we}, 1);
        chk("edge_addr", {13'd0, mem_addr}, 32'h03E17);
        @(negedge clk);
        chk("edge_done", {31'd0, done}, 1);

        // full clear
        send(2'b10, 10'd3, 9'd3, 10'd1, 9'd1, 24'hFFFFFF);
        nw = 0;
        bad = 0;
        prev_we = 1'b0;
        seen_done = 1'b0;
        last_a = '0;
        for (int k = 0; k < 2000 && !seen_done; k++) begin
            if (done) begin
                seen_done = 1'b1;
                chk("clr_done_gap", {31'd0, prev_we}, 1);
            end else begin
                if (mem_we) begin
                    if (mem_addr !== xy(10'(nw % HM), 9'(nw / HM)) || mem_wdata !== 24'd0)
                        bad++;
                    last_a = mem_addr;
                    nw++;
                end
                if (err) bad++;
                prev_we = mem_we;
                @(negedge clk);
            end
        end
        chk("clr_seen_done", {31'd0, seen_done}, 1);
        chk("clr_count", nw, HM * VM);
        chk("clr_bad", bad, 0);
        chk("clr_last", {13'd0, last_a}, 32'h03E17);

        // vblank-gated 4-pixel fill
        sync_en = 1'b1;
        vblank = 1'b1;
        send(2'b01, 10'd2, 9'd7, 10'd5, 9'd7, 24'h123456);
        gi = 0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("sync_we%0d", i), {31'd0, mem_we}, {31'd0, vb_seq[i]});
            if (vb_seq[i]) begin
                chk($sformatf("sync_addr%0d", i), {13'd0, mem_addr}, {13'd0, g_a[gi]});
                gi++;
            end else begin
                chk($sformatf("sync_hold%0d", i), {13'd0, mem_addr}, {13'd0, g_a[gi-1]});
            end
            chk($sformatf("sync_done%0d", i), {31'd0, done}, 0);
            if (i < 6) vblank = vb_seq[i+1];
            @(negedge clk);
        end
        chk("sync_done", {31'd0, done}, 1);
        chk("sync_data", {8'd0, mem_wdata}, 32'h123456);
        sync_en = 1'b0;
        vblank = 1'b0;

        // reset during the third write of a 16-pixel fill
        send(2'b01, 10'd0, 9'd0, 10'd7, 9'd1, 24'h0F0F0F);
        repeat (2) @(negedge clk);
        chk("rst3_we", {31'd0, mem_we}, 1);
        chk("rst3_addr", {13'd0, mem_addr}, 32'h00400);
        #2 rst = 1'b0;
        #1;
        chk("rst3_we_drop", {31'd0, mem_we}, 0);
        chk("rst3_busy_drop", {31'd0, busy}, 0);
        @(negedge clk);
        rst = 1'b1;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || mem_we || busy) stray++;
        end
        chk("rst3_stray", stray, 0);
        chk("rst3_ready", {31'd0, bus.cmd_ready}, 1);
        send(2'b00, 10'd1, 9'd1, 10'd0, 9'd0, 24'hABCDEF);
        chk("post_we", {31'd0, mem_we}, 1);
        chk("post_addr", {13'd0, mem_addr}, 32'h00201);
        chk("post_data", {8'd0, mem_wdata}, 32'hABCDEF);
        @(negedge clk);
        chk("post_done", {31'd0, done}, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vmem_writer.md
Name: vmem_writer

Overview:
- Write-side engine for the 24-bit video memory scanned by the VGA timing path.
- Accepts drawing commands over a valid/ready handshake: single pixel, filled rectangle, full-screen clear.
- Emits one memory write per cycle on a write port using the same addressing as the display read side: address = {x[9:0], y[8:0]}, 19 bits.
- Can optionally restrict writes to vertical blanking to avoid tearing.

Parameters:
- H_BITS, 10, width of x coordinate.
- V_BITS, 9, width of y coordinate.
- DATA_W, 24, pixel width, {R[7:0],G[7:0],B[7:0]}.
- H_MAX, 640, visible width; legal x is 0..H_MAX-1.
- V_MAX, 480, visible height; legal y is 0..V_MAX-1.

Ports:
- clk  in  1  pixel/system clock.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  2  00 pixel, 01 fill rect, 10 clear, 11 reserved.
- cmd_x0  in  H_BITS  start x / pixel x.
- cmd_y0  in  V_BITS  start y / pixel y.
- cmd_x1  in  H_BITS  end x, inclusive (fill only).
- cmd_y1  in  V_BITS  end y, inclusive (fill only).
- cmd_color  in  DATA_W  write colour (clear always writes 0).
- sync_en  in  1  1 = write only while vblank=1.
- vblank  in  1  vertical blanking indicator from the timing generator.
- mem_we  out  1  write strobe.
- mem_addr  out  H_BITS+V_BITS  {x,y}.
- mem_wdata  out  DATA_W  write data.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse on command completion.
- err  out  1  one-cycle pulse on rejected command.

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to IDLE.
  - cmd_ready=1 on release; mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0.
  - Any in-flight command is abandoned with no further writes.
- All outputs are registered.
- FSM states:
  - IDLE: cmd_ready=1, busy=0. On cmd_valid&cmd_ready at edge T, latch the command, validate it, then go to RUN or ERR.
  - RUN: cmd_ready=0, busy=1. Cursor (x,y) starts at (x0,y0); x is the inner loop, y the outer loop.
    - Each enabled cycle issues mem_we=1, mem_addr={x,y}, mem_wdata=colour.
    - Advance rule: if x==x1 then x<=x0 and y<=y+1, else x<=x+1.
    - After the write at (x1,y1), go to FIN.
  - FIN: done=1 for one cycle, cmd_ready=1 in the same cycle, then IDLE.
  - ERR: err=1 for one cycle, no write, cmd_ready=1 in the same cycle, then IDLE.
- Command decoding:
  - Pixel: treated as a rectangle with x1=x0, y1=y0.
  - Clear: x0=0, y0=0, x1=H_MAX-1, y1=V_MAX-1, colour=0. Its coordinate inputs are ignored.
- Validation (pixel/fill) fails, giving ERR, when any of these holds:
  - x0>x1 or y0>y1;
  - x1>=H_MAX or y1>=V_MAX;
  - cmd_op=11.
- Timing with sync_en=0:
  - First write occurs in cycle T+1.
  - N pixels produce writes in cycles T+1..T+N.
  - done is high in T+N+1.
  - The next command can be accepted at edge T+N+1.
- Write gating:
  - With sync_en=1, a write occurs only in cycles where vblank=1 (sampled at that edge). Otherwise mem_we=0 and the cursor holds.
  - sync_en is sampled every cycle, not latched.
- mem_addr/mem_wdata hold their last values when mem_we=0.
- cmd_* inputs are don't-care outside the handshake and while busy.
- A new command can never overlap an active one. err and done are never high in the same cycle.
- Cursor counters are exactly H_BITS/V_BITS wide. The range check guarantees no wrap.

Test Plan:
- Pixel (op 00, x0=5, y0=3, colour 0xFF0000) accepted at T -> mem_we=1 at T+1 with mem_addr={10'd5,9'd3}=0x00A03, data 0xFF0000; done at T+2.
- Fill (op 01, x0=10,y0=20,x1=11,y1=21, colour 0x00FF00) -> four writes in order {10,20},{11,20},{10,21},{11,21} in T+1..T+4; done at T+5; busy high for T+1..T+4.
- Bad fill (x0=12, x1=11) and pixel x0=640 -> err pulse at T+1, no mem_we, cmd_ready high at T+1.
- Clear with sync_en=0 -> exactly 307200 writes of 0, last at address {639,479}; done one cycle after the last write.
- Fill 4 pixels with sync_en=1, vblank toggling 1,0,0,1,1,0,1 -> writes only on vblank=1 cycles; cursor holds otherwise; done after the 4th write.
- Assert rst low during the third write of a 16-pixel fill -> mem_we drops immediately; after release cmd_ready=1, busy=0, no done pulse, and a following pixel command works normally.
